// File: rtl/bus_arbiter.sv
// Four-master bus arbiter with active-low requests/grants, rotating search
// order starting after the current owner, and a hold limit for fairness.
//
// Ports:
//   clk                 : clock, all state updates on rising edge
//   reset               : asynchronous reset, active-high
//   m0_req_ .. m3_req_  : bus requests from masters 0..3, active-low
//   m0_grnt_ .. m3_grnt_: registered bus grants to masters 0..3, active-low
//   owner               : registered index of the master holding the bus
//   hold_cnt            : registered count of consecutive owner-request cycles
module bus_arbiter #(
    parameter int unsigned HOLD_LIMIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output logic [1:0] owner,
    output logic [7:0] hold_cnt
);

    localparam logic [7:0] HOLD_MAX = 8'(HOLD_LIMIT - 1);

    logic [3:0] req;
    logic [1:0] owner_q, owner_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] grnt_q, grnt_d;
    logic       found;
    logic [1:0] cand;
    logic       owner_req;

    // Active-high view of the requests, bit i = master i.
    assign req = ~{m3_req_, m2_req_, m1_req_, m0_req_};
    assign owner_req = req[owner_q];

    // First requesting master after the owner, wrapping modulo 4.
    always_comb begin
        found = 1'b0;
        cand  = owner_q;
        for (int k = 3; k >= 1; k--) begin
            if (req[owner_q + 2'(k)]) begin
                found = 1'b1;
                cand  = owner_q + 2'(k);
            end
        end
    end

    always_comb begin
        owner_d = owner_q;
        hold_d  = hold_q;
        if (!owner_req) begin
            // Owner released: hand over if anyone waits, else park.
            hold_d = 8'd0;
            if (found) begin
                owner_d = cand;
            end
        end else if (hold_q == HOLD_MAX && found) begin
            // Owner used up its turn while someone else waits.
            owner_d = cand;
            hold_d  = 8'd0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 8'd1;
        end
    end

    // Grants are decoded from the next owner and registered, so the
    // outputs never see a combinational path from the requests.
    assign grnt_d = ~(4'b0001 << owner_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= 2'd0;
            hold_q  <= 8'd0;
            grnt_q  <= 4'b1110;
        end else begin
            owner_q <= owner_d;
            hold_q  <= hold_d;
            grnt_q  <= grnt_d;
        end
    end

    assign owner    = owner_q;
    assign hold_cnt = hold_q;
    assign m0_grnt_ = grnt_q[0];
    assign m1_grnt_ = grnt_q[1];
    assign m2_grnt_ = grnt_q[2];
    assign m3_grnt_ = grnt_q[3];

endmodule
